exp_alpha_sched: RTL and testbench
==================================

Name: exp_alpha_sched

Overview:
Controller that sequences the smoothing coefficient of the exponential averaging datapath. On start, it clears the averager and runs a power-of-two warm-up ramp on alpha, from ~1 down to the user target, so the average converges in about 2^k samples instead of 1/alpha. It then tracks at the target alpha, supports freeze (hold) and stop, and flags when the output has settled.

Parameters:
ALPHA_WIDTH, 32, width of the alpha word; alpha_o/2^ALPHA_WIDTH is the fractional gain.
SETTLE_WIDTH, 32, width of the settle-length input and the settle counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  pulse: (re)start averaging sequence
stop_i  in  1  pulse: return to IDLE, freeze averager
hold_i  in  1  level: freeze averager while high
sample_i  in  1  qualifier: one averager update this cycle (tie high if averager updates every clock)
alpha_target_i  in  ALPHA_WIDTH  steady-state alpha (unsigned)
settle_len_i  in  SETTLE_WIDTH  qualified samples in TRACK before settled_o asserts
alpha_o  out  ALPHA_WIDTH  alpha to averager, registered
avg_rst_o  out  1  reset to averager, registered one-cycle pulse
busy_o  out  1  high in CLEAR/WARMUP/TRACK/HOLD
settled_o  out  1  settled flag, registered

Behaviour:
- Reset (rst_i, highest priority): state IDLE, alpha_o=0, avg_rst_o=0, busy_o=0, settled_o=0, all counters 0.
- States: IDLE, CLEAR, WARMUP, TRACK, HOLD. All outputs are registered and reflect the state entered on that edge.
- Priority per cycle: rst_i > start_i > stop_i > hold_i > sample_i.
- start_i from any state goes to CLEAR: avg_rst_o=1 for exactly 1 cycle, alpha_o=0, settled_o=0, stage k=0, counters cleared. The next cycle is unconditionally WARMUP (start_i is accepted again from WARMUP on).
- stop_i (non-IDLE) goes to IDLE: alpha_o=0, settled_o=0. In IDLE, stop_i is ignored.
- WARMUP stage k: alpha_o = all-ones when k=0, else 1<<(ALPHA_WIDTH-k). Stage k lasts 2^k qualified samples (sample_i=1 and hold_i=0). Stage counter width is ALPHA_WIDTH+1.
  - At the end of stage k, if k+1 > ALPHA_WIDTH, or 1<<(ALPHA_WIDTH-(k+1)) <= alpha_target_i, the next state is TRACK. Otherwise the next stage is k+1.
  - A new alpha_o value takes effect on the cycle after the last counted sample of the previous stage.
- WARMUP with hold_i=1: stay in WARMUP, alpha_o=0, stage counter frozen. The stage alpha is restored on the cycle after hold_i falls.
- TRACK: alpha_o follows alpha_target_i with 1-cycle latency; target changes are applied live.
  - Settle counter increments per qualified sample and saturates at all-ones.
  - settled_o=1 once count >= settle_len_i. settle_len_i=0 means settled_o=1 on the first TRACK cycle.
  - A change of alpha_target_i in TRACK clears the settle counter and settled_o.
- TRACK with hold_i=1: go to HOLD, alpha_o=0, settle counter frozen, settled_o retained. hold_i=0 returns to TRACK with alpha_o=target.
- alpha_target_i=0: warm-up runs to k=ALPHA_WIDTH (alpha_o=1), then TRACK with alpha_o=0 (frozen average).
- alpha_target_i=all-ones: TRACK is entered after the single k=0 sample.
- sample_i=0 cycles in WARMUP/TRACK advance nothing; outputs are held.

Optional Feature:
EXP_ALPHA_SCHED_RAMP_LIMIT_EN
- Defined: adds input max_stage_i (width $clog2(ALPHA_WIDTH+1)). Warm-up also ends, entering TRACK, when stage k reaches max_stage_i after completing its samples. max_stage_i=0 gives TRACK after the single all-ones sample.
- Undefined: port absent; warm-up is bounded only by the target and ALPHA_WIDTH.

Test Plan:
- ALPHA_WIDTH=8, target=0x20, sample_i=1, start_i pulse at cycle 0 -> avg_rst_o=1 at cycle 1. alpha_o sequence from cycle 2: FF, 80, 80, 40, 40, 40, 40, then 20 steady. busy_o=1 from cycle 1.
- Same setup, settle_len_i=5 -> settled_o rises on the 5th qualified TRACK sample. Changing target to 0x10 clears settled_o and it reasserts 5 samples later.
- hold_i high for 3 cycles mid stage k=2 -> alpha_o=0 for those cycles, then 40 resumes. The stage completes after 4 total qualified samples.
- In TRACK with settled_o=1: hold_i -> HOLD, alpha_o=0, settled_o stays 1. stop_i -> IDLE, alpha_o=0, settled_o=0, busy_o=0.
- start_i and stop_i asserted in the same cycle during TRACK -> CLEAR wins; avg_rst_o pulses and the ramp restarts from FF. rst_i mid-WARMUP -> all outputs 0 the next cycle.
- target=0, ALPHA_WIDTH=8 -> ramp ends after stage k=8 (alpha_o=01), then TRACK with alpha_o=00. With EXP_ALPHA_SCHED_RAMP_LIMIT_EN and max_stage_i=2, target=0x01 -> FF, 80, 80, 40×4, then 01.

Source files
------------

// File: rtl/exp_alpha_sched_if.sv
// Control/status bundle between the alpha scheduler and its user.
// EXP_ALPHA_SCHED_RAMP_LIMIT_EN adds the max_stage_i warm-up limit.
interface exp_alpha_sched_if #(
  parameter int ALPHA_WIDTH  = 32,
  parameter int SETTLE_WIDTH = 32
);
  logic                    start_i;
  logic                    stop_i;
  logic                    hold_i;
  logic                    sample_i;
  logic [ALPHA_WIDTH-1:0]  alpha_target_i;
  logic [SETTLE_WIDTH-1:0] settle_len_i;
`ifdef EXP_ALPHA_SCHED_RAMP_LIMIT_EN
  logic [$clog2(ALPHA_WIDTH+1)-1:0] max_stage_i;
`endif
  logic [ALPHA_WIDTH-1:0]  alpha_o;
  logic                    avg_rst_o;
  logic                    busy_o;
  logic                    settled_o;

  modport master (
`ifdef EXP_ALPHA_SCHED_RAMP_LIMIT_EN
    output max_stage_i,
`endif
    output start_i, stop_i, hold_i, sample_i, alpha_target_i, settle_len_i,
    input  alpha_o, avg_rst_o, busy_o, settled_o
  );

  modport slave (
`ifdef EXP_ALPHA_SCHED_RAMP_LIMIT_EN
    input  max_stage_i,
`endif
    input  start_i, stop_i, hold_i, sample_i, alpha_target_i, settle_len_i,
    output alpha_o, avg_rst_o, busy_o, settled_o
  );
endinterface

// File: rtl/exp_alpha_sched.sv
// Exponential-average alpha scheduler: clear, power-of-two warm-up ramp, track/hold.
// EXP_ALPHA_SCHED_RAMP_LIMIT_EN caps the ramp at bus.max_stage_i.
module exp_alpha_sched #(
  parameter int ALPHA_WIDTH  = 32,
  parameter int SETTLE_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  exp_alpha_sched_if.slave     bus
);

  typedef logic [ALPHA_WIDTH-1:0]  alpha_t;
  typedef logic [ALPHA_WIDTH:0]    stage_t;
  typedef logic [SETTLE_WIDTH-1:0] settle_t;

  localparam stage_t K_MAX = stage_t'(ALPHA_WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_WARMUP = 3'd2;
  localparam logic [2:0] S_TRACK  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0] state_q, state_d;
  alpha_t     alpha_q, alpha_d;
  alpha_t     target_q, target_d;
  stage_t     stage_q, stage_d;
  stage_t     cnt_q, cnt_d;
  settle_t    settle_q, settle_d;
  logic       avg_rst_q, avg_rst_d;
  logic       busy_q, busy_d;
  logic       settled_q, settled_d;

  // Stage k gain: all-ones for k=0, else 2^-k; zero past the last stage.
  function automatic alpha_t stage_alpha(input stage_t k);
    alpha_t one = alpha_t'(1);
    if (k == '0)   return '1;
    if (k > K_MAX) return '0;
    return one << (K_MAX - k);
  endfunction

  stage_t  stage_next;
  stage_t  stage_len;
  logic    stage_end;
  logic    ramp_done;
  logic    qualified;
  settle_t settle_inc;

  assign stage_next = stage_q + stage_t'(1);
  assign stage_len  = stage_t'(1) << stage_q;
  assign stage_end  = (cnt_q + stage_t'(1)) == stage_len;
  assign qualified  = bus.sample_i && !bus.hold_i;
  assign settle_inc = (settle_q == '1) ? settle_q : settle_q + settle_t'(1);

`ifdef EXP_ALPHA_SCHED_RAMP_LIMIT_EN
  assign ramp_done = (stage_next > K_MAX) ||
                     (stage_alpha(stage_next) <= bus.alpha_target_i) ||
                     (stage_q >= stage_t'(bus.max_stage_i));
`else
  assign ramp_done = (stage_next > K_MAX) ||
                     (stage_alpha(stage_next) <= bus.alpha_target_i);
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    alpha_d   = alpha_q;
    target_d  = target_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    avg_rst_d = 1'b0;
    busy_d    = busy_q;
    settled_d = settled_q;

    if (bus.start_i && state_q != S_CLEAR) begin
      state_d   = S_CLEAR;
      alpha_d   = '0;
      avg_rst_d = 1'b1;
      busy_d    = 1'b1;
      settled_d = 1'b0;
      stage_d   = '0;
      cnt_d     = '0;
      settle_d  = '0;
    end else if (bus.stop_i && state_q != S_IDLE && state_q != S_CLEAR) begin
      state_d   = S_IDLE;
      alpha_d   = '0;
      busy_d    = 1'b0;
      settled_d = 1'b0;
      stage_d   = '0;
      cnt_d     = '0;
      settle_d  = '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          state_d = S_WARMUP;
          alpha_d = stage_alpha('0);
        end

        S_WARMUP: begin
          if (bus.hold_i) begin
            alpha_d = '0;
          end else begin
            alpha_d = stage_alpha(stage_q);
            if (qualified) begin
              if (!stage_end) begin
                cnt_d = cnt_q + stage_t'(1);
              end else if (ramp_done) begin
                state_d   = S_TRACK;
                alpha_d   = bus.alpha_target_i;
                target_d  = bus.alpha_target_i;
                cnt_d     = '0;
                settle_d  = '0;
                settled_d = (bus.settle_len_i == '0);
              end else begin
                stage_d = stage_next;
                cnt_d   = '0;
                alpha_d = stage_alpha(stage_next);
              end
            end
          end
        end

        S_TRACK, S_HOLD: begin
          if (bus.hold_i) begin
            state_d = S_HOLD;
            alpha_d = '0;
          end else begin
            state_d  = S_TRACK;
            alpha_d  = bus.alpha_target_i;
            target_d = bus.alpha_target_i;
            // A new target restarts settling; the change cycle itself is not counted.
            if (bus.alpha_target_i != target_q) begin
              settle_d  = '0;
              settled_d = 1'b0;
            end else if (bus.sample_i) begin
              settle_d  = settle_inc;
              settled_d = (settle_inc >= bus.settle_len_i);
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          alpha_d = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q   <= S_IDLE;
      alpha_q   <= '0;
      target_q  <= '0;
      stage_q   <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      avg_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alpha_q   <= alpha_d;
      target_q  <= target_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      avg_rst_q <= avg_rst_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
    end
  end

  assign bus.alpha_o   = alpha_q;
  assign bus.avg_rst_o = avg_rst_q;
  assign bus.busy_o    = busy_q;
  assign bus.settled_o = settled_q;

endmodule

// File: tb/tb_exp_alpha_sched.sv
// Directed bench for exp_alpha_sched at ALPHA_WIDTH=8 with hand-computed alpha sequences.
module tb_exp_alpha_sched;

  localparam int AW = 8;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exp_alpha_sched_if #(.ALPHA_WIDTH(AW), .SETTLE_WIDTH(SW)) bus ();

  exp_alpha_sched #(.ALPHA_WIDTH(AW), .SETTLE_WIDTH(SW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs are read 1 time unit after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  logic [7:0] ramp20 [8] = '{8'hFF, 8'h80, 8'h80, 8'h40, 8'h40, 8'h40, 8'h40, 8'h20};
  logic [7:0] hold_seq [7] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h20};
  logic [7:0] hold_in [7] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};

  initial begin
    bus.start_i        = 1'b0;
    bus.stop_i         = 1'b0;
    bus.hold_i         = 1'b0;
    bus.sample_i       = 1'b1;
    bus.alpha_target_i = 8'h20;
    bus.settle_len_i   = 8'd5;
`ifdef EXP_ALPHA_SCHED_RAMP_LIMIT_EN
    bus.max_stage_i    = 4'd8;
`endif
    tick();
    tick();
    rst = 1'b0;

    check("rst_alpha",   bus.alpha_o,   0);
    check("rst_avg_rst", bus.avg_rst_o, 0);
    check("rst_busy",    bus.busy_o,    0);
    check("rst_settled", bus.settled_o, 0);

    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    check("idle_stop_busy", bus.busy_o, 0);

    // Ramp to target 0x20.
    do_start();
    check("clear_avg_rst", bus.avg_rst_o, 1);
    check("clear_alpha",   bus.alpha_o,   0);
    check("clear_busy",    bus.busy_o,    1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("ramp20_%0d", i), bus.alpha_o, ramp20[i]);
    end
    check("track_avg_rst", bus.avg_rst_o, 0);
    check("track_settled0", bus.settled_o, 0);

    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("settle_%0d", i), bus.settled_o, (i >= 5) ? 1 : 0);
    end

    // Target change restarts settling.
    bus.alpha_target_i = 8'h10;
    tick();
    check("retarget_alpha",   bus.alpha_o,   8'h10);
    check("retarget_settled", bus.settled_o, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("resettle_%0d", i), bus.settled_o, (i >= 5) ? 1 : 0);
    end

    // HOLD from TRACK keeps settled, zeroes alpha.
    bus.hold_i = 1'b1;
    tick();
    check("hold_alpha",   bus.alpha_o,   0);
    check("hold_settled", bus.settled_o, 1);
    check("hold_busy",    bus.busy_o,    1);
    tick();
    check("hold2_alpha",  bus.alpha_o,   0);
    bus.hold_i = 1'b0;
    tick();
    check("unhold_alpha",   bus.alpha_o,   8'h10);
    check("unhold_settled", bus.settled_o, 1);

    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    check("stop_alpha",   bus.alpha_o,   0);
    check("stop_settled", bus.settled_o, 0);
    check("stop_busy",    bus.busy_o,    0);

    // Hold in the middle of stage k=2.
    bus.alpha_target_i = 8'h20;
    do_start();
    for (int i = 0; i < 4; i++) tick();
    check("wh_stage2", bus.alpha_o, 8'h40);
    for (int i = 0; i < 7; i++) begin
      bus.hold_i = hold_in[i][0];
      tick();
      check($sformatf("whold_%0d", i), bus.alpha_o, hold_seq[i]);
    end
    bus.hold_i = 1'b0;

    // start and stop together in TRACK: start wins.
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    check("ss_avg_rst", bus.avg_rst_o, 1);
    check("ss_alpha",   bus.alpha_o,   0);
    check("ss_busy",    bus.busy_o,    1);
    tick();
    check("ss_ramp_ff", bus.alpha_o, 8'hFF);
    tick();
    check("ss_ramp_80", bus.alpha_o, 8'h80);

    // Synchronous reset mid-warm-up.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_alpha",   bus.alpha_o,   0);
    check("mrst_avg_rst", bus.avg_rst_o, 0);
    check("mrst_busy",    bus.busy_o,    0);
    check("mrst_settled", bus.settled_o, 0);

    // target=0: full ramp to alpha=1, then frozen average; settle_len=0 settles at once.
    bus.alpha_target_i = 8'h00;
    bus.settle_len_i   = 8'd0;
    do_start();
    for (int k = 0; k <= AW; k++) begin
      logic [7:0] exp_a;
      exp_a = (k == 0) ? 8'hFF : 8'(1 << (AW - k));
      for (int j = 0; j < (1 << k); j++) begin
        tick();
        if (j == 0 || j == (1 << k) - 1)
          check($sformatf("t0_k%0d_j%0d", k, j), bus.alpha_o, exp_a);
      end
    end
    tick();
    check("t0_track_alpha",   bus.alpha_o,   0);
    check("t0_track_busy",    bus.busy_o,    1);
    check("t0_track_settled", bus.settled_o, 1);

    // target=all-ones: TRACK right after the single k=0 sample.
    bus.alpha_target_i = 8'hFF;
    do_start();
    tick();
    check("tff_k0", bus.alpha_o, 8'hFF);
    tick();
    check("tff_track", bus.alpha_o, 8'hFF);
    bus.alpha_target_i = 8'h33;
    tick();
    check("tff_live", bus.alpha_o, 8'h33);

    // sample_i=0 in TRACK holds outputs.
    bus.sample_i = 1'b0;
    tick();
    check("nosample_alpha", bus.alpha_o, 8'h33);
    bus.sample_i = 1'b1;

`ifdef EXP_ALPHA_SCHED_RAMP_LIMIT_EN
    begin
      logic [7:0] lim_seq [8] = '{8'hFF, 8'h80, 8'h80, 8'h40, 8'h40, 8'h40, 8'h40, 8'h01};
      bus.max_stage_i    = 4'd2;
      bus.alpha_target_i = 8'h01;
      do_start();
      for (int i = 0; i < 8; i++) begin
        tick();
        check($sformatf("limit_%0d", i), bus.alpha_o, lim_seq[i]);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
